// File: rtl/tagged_fifo_pkg.sv
// Shared sizing helpers for the tagged {id, data} FIFO.
// Latency: n/a (functions only).
// Backpressure: n/a.
package tagged_fifo_pkg;

   // Number of bits needed to hold an occupancy count in the range 0..depth.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Pointer advance with an explicit wrap at depth-1.
   // DEPTH need not be a power of two, so natural overflow cannot be used.
   function automatic int next_ptr(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/tagged_fifo_mem.sv
// Storage array for the tagged FIFO: DEPTH x WIDTH registers, one write port, one async read port.
// Latency: write lands on the rising edge; read is combinational from rd_addr.
// Backpressure: none; the caller only writes slots it owns. Contents are never reset.
//   clk      in   write clock
//   wr_en    in   write strobe
//   wr_addr  in   write slot
//   wr_data  in   entry to store
//   rd_addr  in   read slot
//   rd_data  out  entry at rd_addr
module tagged_fifo_mem #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tagged_data_fifo.sv
// Synchronous first-word-fall-through FIFO of {id, data} pairs with occupancy count.
// Latency: an entry pushed on edge N is presented on out_* with out_valid=1 right after edge N.
// Backpressure: in_ready = !full and out_valid = !empty, both from the registered count only.
// Optional trace: define TAGGED_FIFO_TRACE_EN to print push/pop lines in simulation.
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        producer handshake for {in_id, in_data}
//   out_valid/out_ready      consumer handshake for {out_id, out_data} (zero while empty)
//   count, full, empty       occupancy 0..DEPTH and its end flags
module tagged_data_fifo
   import tagged_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ID_WIDTH   = 32,
   parameter int DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic [ID_WIDTH-1:0]           in_id,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [ID_WIDTH-1:0]           out_id,
   output logic [cnt_width(DEPTH)-1:0]   count,
   output logic                          full,
   output logic                          empty
);

   localparam int ENTRY_W = DATA_WIDTH + ID_WIDTH;
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = cnt_width(DEPTH);

   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count_nxt;
   logic [ENTRY_W-1:0] rd_entry;
   logic               push;
   logic               pop;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign in_ready  = !full;
   assign out_valid = !empty;

   // A full FIFO refuses input even when a pop happens on the same edge.
   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= PTR_W'(next_ptr(int'(wr_ptr), DEPTH));
         end
         if (pop) begin
            rd_ptr <= PTR_W'(next_ptr(int'(rd_ptr), DEPTH));
         end
         count <= count_nxt;
      end
   end

   tagged_fifo_mem #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data ({in_id, in_data}),
      .rd_addr (rd_ptr),
      .rd_data (rd_entry)
   );

   // Storage is never cleared, so mask the head while empty to keep outputs at zero.
   assign {out_id, out_data} = empty ? '0 : rd_entry;

`ifdef TAGGED_FIFO_TRACE_EN
   initial begin
      $display("tagged_data_fifo DATA_WIDTH=%0d ID_WIDTH=%0d DEPTH=%0d", DATA_WIDTH, ID_WIDTH, DEPTH);
   end

   always @(posedge clk) begin
      if (!rst) begin
         if (push) begin
            $display("push id=%0d data=%0d count=%0d", in_id, in_data, count_nxt);
         end
         if (pop) begin
            $display("pop id=%0d data=%0d count=%0d", out_id, out_data, count_nxt);
         end
      end
   end
`else
`endif

endmodule

// File: tb/tb_tagged_data_fifo.sv
module tb_tagged_data_fifo;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: DATA 8, ID 32, DEPTH 4
   logic        a_iv = 0, a_ir, a_ov, a_or = 0, a_full, a_empty;
   logic [7:0]  a_idat = '0, a_odat;
   logic [31:0] a_iid = '0, a_oid;
   logic [2:0]  a_count;
   // Instance B: DATA 8, ID 32, DEPTH 3
   logic        b_iv = 0, b_ir, b_ov, b_or = 0, b_full, b_empty;
   logic [7:0]  b_idat = '0, b_odat;
   logic [31:0] b_iid = '0, b_oid;
   logic [1:0]  b_count;
   // Instance C: DATA 1, ID 64, DEPTH 4
   logic        c_iv = 0, c_ir, c_ov, c_or = 0, c_full, c_empty;
   logic [0:0]  c_idat = '0, c_odat;
   logic [63:0] c_iid = '0, c_oid;
   logic [2:0]  c_count;

   logic [39:0] qa[$];
   logic [39:0] qb[$];
   logic [64:0] qc[$];

   tagged_data_fifo #(.DATA_WIDTH(8), .ID_WIDTH(32), .DEPTH(4)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_idat), .in_id(a_iid),
      .out_valid(a_ov), .out_ready(a_or), .out_data(a_odat), .out_id(a_oid),
      .count(a_count), .full(a_full), .empty(a_empty));

   tagged_data_fifo #(.DATA_WIDTH(8), .ID_WIDTH(32), .DEPTH(3)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_idat), .in_id(b_iid),
      .out_valid(b_ov), .out_ready(b_or), .out_data(b_odat), .out_id(b_oid),
      .count(b_count), .full(b_full), .empty(b_empty));

   tagged_data_fifo #(.DATA_WIDTH(1), .ID_WIDTH(64), .DEPTH(4)) dut_c (
      .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_idat), .in_id(c_iid),
      .out_valid(c_ov), .out_ready(c_or), .out_data(c_odat), .out_id(c_oid),
      .count(c_count), .full(c_full), .empty(c_empty));

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Monitors: a pop happens on the next rising edge whenever valid&ready hold at the falling edge.
   always @(negedge clk) begin
      if (!rst && a_ov && a_or) begin
         if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_pop_unexpected: got %0h required no output", {a_oid, a_odat});
         end else begin
            check("a_pop", {a_oid, a_odat}, qa.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && b_ov && b_or) begin
         if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_pop_unexpected: got %0h required no output", {b_oid, b_odat});
         end else begin
            check("b_pop", {b_oid, b_odat}, qb.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && c_ov && c_or) begin
         if (qc.size() == 0) begin
            checks++; errors++;
            $display("FAIL c_pop_unexpected: got %0h required no output", {c_oid, c_odat});
         end else begin
            check("c_pop", {c_oid, c_odat}, qc.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One-cycle offer on A; accepted entries go into the scoreboard.
   task automatic a_push(input logic [31:0] id, input logic [7:0] d, input bit accept);
      a_iv = 1'b1; a_iid = id; a_idat = d;
      if (accept) qa.push_back({id, d});
      tick(1);
      a_iv = 1'b0;
   endtask

   initial begin
      // Reset state
      #3;
      check("rst_count", a_count, 0);
      check("rst_empty", a_empty, 1);
      check("rst_full", a_full, 0);
      check("rst_in_ready", a_ir, 1);
      check("rst_out_valid", a_ov, 0);
      check("rst_out_zero", {a_oid, a_odat}, 0);
      tick(1);
      rst = 1'b0;

      // 1: async reset mid-stream with three entries held
      a_push(32'd100, 8'h10, 1);
      a_push(32'd101, 8'h11, 1);
      a_push(32'd102, 8'h12, 1);
      check("t1_count3", a_count, 3);
      #1; rst = 1'b1; qa.delete();
      #1;
      check("t1_async_count", a_count, 0);
      check("t1_async_empty", a_empty, 1);
      check("t1_async_in_ready", a_ir, 1);
      check("t1_async_out_valid", a_ov, 0);
      tick(1);
      rst = 1'b0;
      a_push(32'd7, 8'd1, 1);
      check("t1_fwft_valid", a_ov, 1);
      check("t1_fwft_head", {a_oid, a_odat}, {32'd7, 8'd1});
      check("t1_count1", a_count, 1);
      a_or = 1'b1; tick(1); a_or = 1'b0;
      check("t1_empty", a_empty, 1);

      // 2: fill to DEPTH, drop the overflow offer, drain in order
      for (int i = 0; i < 4; i++) a_push(32'(i + 1), 8'(8'hA0 + i), 1);
      check("t2_full", a_full, 1);
      check("t2_count4", a_count, 4);
      check("t2_in_ready", a_ir, 0);
      a_push(32'd5, 8'hA4, 0);
      check("t2_count_after_drop", a_count, 4);
      a_or = 1'b1; tick(4); a_or = 1'b0;
      check("t2_drained_empty", a_empty, 1);
      check("t2_drained_count", a_count, 0);

      // 3: simultaneous push and pop at count 2
      a_push(32'd20, 8'h20, 1);
      a_push(32'd21, 8'h21, 1);
      a_or = 1'b1;
      a_push(32'd9, 8'h09, 1);
      a_or = 1'b0;
      check("t3_count2", a_count, 2);
      check("t3_head", a_oid, 21);
      a_or = 1'b1; tick(2); a_or = 1'b0;
      check("t3_empty", a_empty, 1);

      // 4: full with offer and pop on the same edge -> pop only
      for (int i = 0; i < 4; i++) a_push(32'(30 + i), 8'(8'h30 + i), 1);
      a_or = 1'b1;
      a_push(32'd99, 8'h99, 0);
      a_or = 1'b0;
      check("t4_count3", a_count, 3);
      check("t4_head", a_oid, 31);
      a_or = 1'b1; tick(3); a_or = 1'b0;
      check("t4_empty", a_empty, 1);
      check("t4_count0", a_count, 0);

      // 5: DEPTH=3 wrap, ids 0..9 streamed with two entries in flight
      for (int i = 0; i < 10; i++) begin
         b_iv = 1'b1; b_iid = 32'(i); b_idat = 8'(8'h40 + i);
         qb.push_back({32'(i), 8'(8'h40 + i)});
         if (i == 2) b_or = 1'b1;
         tick(1);
         check("t5_count_le3", b_count <= 2'd3, 1);
      end
      b_iv = 1'b0;
      check("t5_count_stream", b_count, 2);
      tick(3);
      b_or = 1'b0;
      check("t5_empty", b_empty, 1);

      // 6: DATA_WIDTH=1, ID_WIDTH=64
      c_iv = 1'b1; c_iid = 64'hFFFF_0000_1234_5678; c_idat = 1'b1;
      qc.push_back({64'hFFFF_0000_1234_5678, 1'b1});
      tick(1);
      c_iv = 1'b0;
      check("t6_id", c_oid, 64'hFFFF_0000_1234_5678);
      check("t6_data", c_odat, 1);
      c_or = 1'b1; tick(1); c_or = 1'b0;
      check("t6_empty", c_empty, 1);

      // Every expected entry must have been seen
      check("qa_left", qa.size(), 0);
      check("qb_left", qb.size(), 0);
      check("qc_left", qc.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
